aurora_link_ctrl: RTL and testbench
===================================

Name: aurora_link_ctrl

Overview:
- Bring-up and recovery sequencer for the Aurora 64b66b RX/TX link pair in the tnet block; runs in the init_clk domain.
- Drives the shared reset_pb / pma_init pair in the required order: reset_pb asserted before pma_init, and released after it.
- Waits for a stable channel_up with a timeout, retries a bounded number of times, then re-runs the sequence whenever the link drops.
- Exposes status and counters for the AXI-Lite register bank and for aurora_dbg.

Parameters:
- PB_LEAD, 128: init_clk cycles reset_pb is held before pma_init asserts (recovery path only).
- PMA_HOLD, 1024: cycles pma_init is held asserted.
- POST_HOLD, 128: cycles reset_pb stays asserted after pma_init release.
- UP_TIMEOUT, 1048576: cycles allowed in WAIT_UP before a retry.
- UP_STABLE, 16: consecutive synchronized channel_up-high cycles required to declare the link up.
- MAX_RETRY, 15: consecutive timeouts before FAIL; 0 means retry forever.

Ports:
- init_clk  in  1  sequencer clock (~15 MHz from the PS clock wizard).
- init_rst  in  1  asynchronous, active-high reset.
- enable_i  in  1  level; 0 forces IDLE.
- restart_i  in  1  single-cycle pulse; forces a full re-sequence.
- channel_up_i  in  1  async (user_clk domain); AND of RX and TX channel_up.
- gt_pll_lock_i  in  1  async; must be 1 to leave PB_HOLD.
- reset_pb_o  out  1  to Aurora reset_pb.
- pma_init_o  out  1  to Aurora pma_init.
- link_ok_o  out  1  high only in UP.
- fail_o  out  1  high only in FAIL.
- state_o  out  3  state encoding, listed below.
- retry_cnt_o  out  8  consecutive timeouts; saturating.
- drop_cnt_o  out  16  link drops seen in UP; saturating.

Behaviour:
- Synchronization: channel_up_i and gt_pll_lock_i each pass through a 2-FF synchronizer, giving 2 cycles of latency. All logic below uses the synchronized values (cu_s, pll_s).
- Outputs: all registered and decoded from the state register. Reset values: reset_pb_o=1, pma_init_o=1, link_ok_o=0, fail_o=0, state_o=0, retry_cnt_o=0, drop_cnt_o=0.
- States and output encoding (reset_pb, pma_init):
  - IDLE=0: (1,1).
  - PB_LEAD=1: (1,0).
  - PMA=2: (1,1).
  - PB_HOLD=3: (1,0).
  - WAIT_UP=4: (0,0).
  - UP=5: (0,0).
  - FAIL=6: (1,1).
- One shared down-counter, sized for the largest parameter. It is loaded on every state entry.
- Transitions:
  - IDLE: enable_i=1 -> PMA; PB_LEAD is skipped because reset_pb is already high.
  - PB_LEAD: after PB_LEAD cycles -> PMA.
  - PMA: after PMA_HOLD cycles -> PB_HOLD.
  - PB_HOLD: after POST_HOLD cycles and pll_s=1 -> WAIT_UP. If pll_s=0, stay until it rises; the counter is already expired.
  - WAIT_UP: cu_s high for UP_STABLE consecutive cycles -> UP, and retry_cnt clears. A low cycle on cu_s restarts the stability count.
  - WAIT_UP timeout: after UP_TIMEOUT cycles without UP, retry_cnt increments. If MAX_RETRY!=0 and the new count >= MAX_RETRY -> FAIL; otherwise -> PB_LEAD.
  - UP: cu_s=0 for one cycle -> drop_cnt increments, then -> PB_LEAD.
  - FAIL: holds until restart_i or enable_i=0.
- Priority, highest first:
  1. enable_i=0 -> IDLE from any state.
  2. restart_i=1, in any non-IDLE state -> PB_LEAD, and retry_cnt clears. restart_i in IDLE is ignored.
  3. Normal transitions.
- Simultaneous events:
  - A timeout and the final stable cycle in the same cycle: UP wins.
  - A drop in UP and restart_i in the same cycle: drop_cnt still increments.
- Counters saturate at all-ones; there is no wrap. drop_cnt clears only on init_rst.
- Reset mid-operation: async init_rst immediately forces IDLE with both resets asserted. The synchronizer flops reset to 0.

Decomposition:
- Shared package tnet_pkg: state enum link_st_t (3-bit encodings as above) and constant LINK_CNT_W = $clog2 of the largest timing parameter, plus 1.
- One sub-module, sync_2ff (parameterizable width), reused for both async inputs.

Test Plan (PB_LEAD=4, PMA_HOLD=8, POST_HOLD=4, UP_TIMEOUT=32, UP_STABLE=3, MAX_RETRY=2):
- Release reset, set enable_i=1, pll=1, then raise channel_up after WAIT_UP entry -> pma_init high for exactly 8 cycles, reset_pb falls 4 cycles after pma_init falls; link_ok_o=1 exactly 2+3 cycles after channel_up rises.
- channel_up never rises -> two 32-cycle WAIT_UP windows, retry_cnt_o=1 then 2, fail_o=1, state_o=6, reset_pb_o=pma_init_o=1; a restart_i pulse then gives state_o=1 and retry_cnt_o=0.
- Link UP, then drop channel_up for 1 cycle -> drop_cnt_o=1 and state PB_LEAD with reset_pb_o=1, pma_init_o=0 for 4 cycles before PMA.
- Hold pll_lock=0 -> state stays at 3 indefinitely; raising pll moves to WAIT_UP 3 cycles later (2 sync plus 1 registered).
- Assert init_rst in the middle of PMA -> all outputs take their reset values within the same cycle; deassert enable_i in UP -> IDLE next cycle, link_ok_o=0.
- Glitch channel_up high for 2 cycles, then low, in WAIT_UP -> no UP entry and the stability count restarts.

Source files
------------

// File: rtl/tnet_pkg.sv
// Shared types for the tnet Aurora link control logic.
// Holds the link sequencer state encoding and the timing counter width.
package tnet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PB_LEAD = 3'd1,
        ST_PMA     = 3'd2,
        ST_PB_HOLD = 3'd3,
        ST_WAIT_UP = 3'd4,
        ST_UP      = 3'd5,
        ST_FAIL    = 3'd6
    } link_st_t;

    // Wide enough for the largest timing parameter (UP_TIMEOUT).
    localparam int unsigned LINK_CNT_W = $clog2(1048576) + 1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow async level signals.
// Ports: clk, rst (async high, flops clear to 0), d_i async in, q_o synced.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/aurora_link_ctrl.sv
// Aurora 64b66b bring-up / recovery sequencer (init_clk domain).
// Ports: enable/restart controls, async channel_up and pll lock inputs,
// reset_pb / pma_init drives, link_ok/fail status, state and counters.
module aurora_link_ctrl
    import tnet_pkg::*;
#(
    parameter int unsigned PB_LEAD    = 128,
    parameter int unsigned PMA_HOLD   = 1024,
    parameter int unsigned POST_HOLD  = 128,
    parameter int unsigned UP_TIMEOUT = 1048576,
    parameter int unsigned UP_STABLE  = 16,
    parameter int unsigned MAX_RETRY  = 15
) (
    input  logic        init_clk,
    input  logic        init_rst,
    input  logic        enable_i,
    input  logic        restart_i,
    input  logic        channel_up_i,
    input  logic        gt_pll_lock_i,
    output logic        reset_pb_o,
    output logic        pma_init_o,
    output logic        link_ok_o,
    output logic        fail_o,
    output logic [2:0]  state_o,
    output logic [7:0]  retry_cnt_o,
    output logic [15:0] drop_cnt_o
);

    typedef logic [LINK_CNT_W-1:0] cnt_t;
    localparam int unsigned STAB_W = $clog2(UP_STABLE + 1);
    typedef logic [STAB_W-1:0] stab_t;

    logic     cu_s, pll_s;
    link_st_t state_q, state_d;
    cnt_t     cnt_q, cnt_d;
    stab_t    stab_q, stab_d;
    logic [7:0]  retry_q, retry_d, retry_inc;
    logic [15:0] drop_q, drop_d;
    logic     enter;
    logic     reset_pb_q, reset_pb_d;
    logic     pma_init_q, pma_init_d;
    logic     link_ok_q, link_ok_d;
    logic     fail_q, fail_d;

    sync_2ff #(.W(1)) u_sync_cu (
        .clk (init_clk),
        .rst (init_rst),
        .d_i (channel_up_i),
        .q_o (cu_s)
    );

    sync_2ff #(.W(1)) u_sync_pll (
        .clk (init_clk),
        .rst (init_rst),
        .d_i (gt_pll_lock_i),
        .q_o (pll_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        stab_d    = '0;
        retry_d   = retry_q;
        drop_d    = drop_q;
        enter     = 1'b0;
        retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

        // A drop is counted even if restart or disable wins the transition.
        if (state_q == ST_UP && !cu_s && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;

        if (!enable_i) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                enter   = 1'b1;
            end
        end else if (restart_i && state_q != ST_IDLE) begin
            state_d = ST_PB_LEAD;
            retry_d = '0;
            enter   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_PMA;
                    enter   = 1'b1;
                end
                ST_PB_LEAD: if (cnt_q == '0) begin
                    state_d = ST_PMA;
                    enter   = 1'b1;
                end
                ST_PMA: if (cnt_q == '0) begin
                    state_d = ST_PB_HOLD;
                    enter   = 1'b1;
                end
                ST_PB_HOLD: if (cnt_q == '0 && pll_s) begin
                    state_d = ST_WAIT_UP;
                    enter   = 1'b1;
                end
                ST_WAIT_UP: begin
                    stab_d = cu_s ? stab_q + 1'b1 : '0;
                    // Stability is checked first so it beats a timeout.
                    if (cu_s && stab_q == stab_t'(UP_STABLE - 1)) begin
                        state_d = ST_UP;
                        retry_d = '0;
                        enter   = 1'b1;
                    end else if (cnt_q == '0) begin
                        retry_d = retry_inc;
                        enter   = 1'b1;
                        if (MAX_RETRY != 0 && {24'd0, retry_inc} >= MAX_RETRY)
                            state_d = ST_FAIL;
                        else
                            state_d = ST_PB_LEAD;
                    end
                end
                ST_UP: if (!cu_s) begin
                    state_d = ST_PB_LEAD;
                    enter   = 1'b1;
                end
                ST_FAIL: ;
                default: begin
                    state_d = ST_IDLE;
                    enter   = 1'b1;
                end
            endcase
        end

        if (enter) begin
            stab_d = '0;
            case (state_d)
                ST_PB_LEAD: cnt_d = cnt_t'(PB_LEAD - 1);
                ST_PMA:     cnt_d = cnt_t'(PMA_HOLD - 1);
                ST_PB_HOLD: cnt_d = cnt_t'(POST_HOLD - 1);
                ST_WAIT_UP: cnt_d = cnt_t'(UP_TIMEOUT - 1);
                default:    cnt_d = '0;
            endcase
        end

        reset_pb_d = 1'b1;
        pma_init_d = 1'b1;
        case (state_d)
            ST_PB_LEAD, ST_PB_HOLD: pma_init_d = 1'b0;
            ST_WAIT_UP, ST_UP: begin
                reset_pb_d = 1'b0;
                pma_init_d = 1'b0;
            end
            default: ;
        endcase
        link_ok_d = (state_d == ST_UP);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge init_clk or posedge init_rst) begin
        if (init_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            stab_q     <= '0;
            retry_q    <= '0;
            drop_q     <= '0;
            reset_pb_q <= 1'b1;
            pma_init_q <= 1'b1;
            link_ok_q  <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stab_q     <= stab_d;
            retry_q    <= retry_d;
            drop_q     <= drop_d;
            reset_pb_q <= reset_pb_d;
            pma_init_q <= pma_init_d;
            link_ok_q  <= link_ok_d;
            fail_q     <= fail_d;
        end
    end

    assign reset_pb_o  = reset_pb_q;
    assign pma_init_o  = pma_init_q;
    assign link_ok_o   = link_ok_q;
    assign fail_o      = fail_q;
    assign state_o     = state_q;
    assign retry_cnt_o = retry_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_aurora_link_ctrl.sv
// Self-checking bench for aurora_link_ctrl with shortened timing.
// Vector table, directed corner sequences, then random vs. a reference model.
module tb_aurora_link_ctrl;

    localparam int P_LEAD  = 4;
    localparam int P_PMA   = 8;
    localparam int P_POST  = 4;
    localparam int P_TO    = 32;
    localparam int P_STAB  = 3;
    localparam int P_RETRY = 2;

    localparam int S_IDLE = 0, S_PBL = 1, S_PMA = 2, S_PBH = 3;
    localparam int S_WAIT = 4, S_UP = 5, S_FAIL = 6;

    logic        init_clk = 1'b0;
    logic        init_rst = 1'b1;
    logic        enable_i = 1'b0;
    logic        restart_i = 1'b0;
    logic        channel_up_i = 1'b0;
    logic        gt_pll_lock_i = 1'b0;
    logic        reset_pb_o, pma_init_o, link_ok_o, fail_o;
    logic [2:0]  state_o;
    logic [7:0]  retry_cnt_o;
    logic [15:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 init_clk = ~init_clk;

    aurora_link_ctrl #(
        .PB_LEAD    (P_LEAD),
        .PMA_HOLD   (P_PMA),
        .POST_HOLD  (P_POST),
        .UP_TIMEOUT (P_TO),
        .UP_STABLE  (P_STAB),
        .MAX_RETRY  (P_RETRY)
    ) dut (
        .init_clk      (init_clk),
        .init_rst      (init_rst),
        .enable_i      (enable_i),
        .restart_i     (restart_i),
        .channel_up_i  (channel_up_i),
        .gt_pll_lock_i (gt_pll_lock_i),
        .reset_pb_o    (reset_pb_o),
        .pma_init_o    (pma_init_o),
        .link_ok_o     (link_ok_o),
        .fail_o        (fail_o),
        .state_o       (state_o),
        .retry_cnt_o   (retry_cnt_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    typedef struct {
        logic        en;
        logic        pll;
        logic        cu;
        int          n;
        logic [2:0]  st;
        logic        rpb;
        logic        pma;
        logic        ok;
        logic [7:0]  rc;
        logic [15:0] dc;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    int   m_st, m_age, m_run, m_retry, m_drop;
    logic cu_q[$];
    logic pll_q[$];

    task automatic tick();
        @(posedge init_clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int st, input logic rpb,
                           input logic pma, input logic ok, input logic fl,
                           input int rc, input int dc);
        checks++;
        if (state_o !== 3'(st) || reset_pb_o !== rpb || pma_init_o !== pma ||
            link_ok_o !== ok || fail_o !== fl || retry_cnt_o !== 8'(rc) ||
            drop_cnt_o !== 16'(dc)) begin
            errors++;
            $display("FAIL %s: got st=%0d rpb=%b pma=%b ok=%b fail=%b rc=%0d dc=%0d want st=%0d rpb=%b pma=%b ok=%b fail=%b rc=%0d dc=%0d",
                     nm, state_o, reset_pb_o, pma_init_o, link_ok_o, fail_o,
                     retry_cnt_o, drop_cnt_o, st, rpb, pma, ok, fl, rc, dc);
        end
    endtask

    function automatic logic exp_rpb(int st);
        return !(st == S_WAIT || st == S_UP);
    endfunction

    function automatic logic exp_pma(int st);
        return (st == S_IDLE || st == S_PMA || st == S_FAIL);
    endfunction

    function automatic void model_reset();
        m_st = S_IDLE;
        m_age = 1;
        m_run = 0;
        m_retry = 0;
        m_drop = 0;
        cu_q = '{1'b0, 1'b0};
        pll_q = '{1'b0, 1'b0};
    endfunction

    function automatic void model_step(logic en, logic rs, logic cu, logic pll);
        logic cs, ps;
        int   nx;
        bit   reenter;
        cs = cu_q.pop_front();
        cu_q.push_back(cu);
        ps = pll_q.pop_front();
        pll_q.push_back(pll);
        nx = m_st;
        reenter = 0;
        if (m_st == S_UP && !cs && m_drop < 65535) m_drop++;
        if (!en) begin
            nx = S_IDLE;
            reenter = (m_st != S_IDLE);
        end else if (rs && m_st != S_IDLE) begin
            nx = S_PBL;
            m_retry = 0;
            reenter = 1;
        end else begin
            case (m_st)
                S_IDLE: nx = S_PMA;
                S_PBL:  if (m_age >= P_LEAD) nx = S_PMA;
                S_PMA:  if (m_age >= P_PMA) nx = S_PBH;
                S_PBH:  if (m_age >= P_POST && ps) nx = S_WAIT;
                S_WAIT: begin
                    m_run = cs ? m_run + 1 : 0;
                    if (m_run >= P_STAB) begin
                        nx = S_UP;
                        m_retry = 0;
                    end else if (m_age >= P_TO) begin
                        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                        nx = (P_RETRY != 0 && m_retry >= P_RETRY) ? S_FAIL : S_PBL;
                    end
                end
                S_UP: if (!cs) nx = S_PBL;
                default: ;
            endcase
            reenter = (nx != m_st);
        end
        if (reenter) begin
            m_age = 1;
            m_run = 0;
        end else begin
            m_age++;
        end
        m_st = nx;
    endfunction

    task automatic chk_model(input string nm);
        chk_all(nm, m_st, exp_rpb(m_st), exp_pma(m_st), m_st == S_UP,
                m_st == S_FAIL, m_retry, m_drop);
    endtask

    task automatic do_reset();
        init_rst = 1'b1;
        tick();
        tick();
        init_rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_state(input int s, input int lim, input string nm);
        int n = 0;
        while (state_o !== 3'(s) && n < lim) begin
            tick();
            n++;
        end
        chk(nm, int'(state_o), s);
    endtask

    task automatic count_in(input int s, input int lim, output int n);
        n = 1;
        while (n < lim) begin
            tick();
            if (state_o !== 3'(s)) break;
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic r_en, r_rs, r_cu, r_pll;

        // Reset state
        enable_i = 1'b1;
        gt_pll_lock_i = 1'b1;
        channel_up_i = 1'b0;
        tick();
        chk_all("reset", S_IDLE, 1, 1, 0, 0, 0, 0);
        do_reset();

        // Bring-up, drop recovery, disable in UP
        tbl.push_back('{1, 1, 0, 8, 3'd2, 1, 1, 0, 8'd0, 16'd0});
        tbl.push_back('{1, 1, 0, 4, 3'd3, 1, 0, 0, 8'd0, 16'd0});
        tbl.push_back('{1, 1, 0, 1, 3'd4, 0, 0, 0, 8'd0, 16'd0});
        tbl.push_back('{1, 1, 1, 4, 3'd4, 0, 0, 0, 8'd0, 16'd0});
        tbl.push_back('{1, 1, 1, 1, 3'd5, 0, 0, 1, 8'd0, 16'd0});
        tbl.push_back('{1, 1, 1, 3, 3'd5, 0, 0, 1, 8'd0, 16'd0});
        tbl.push_back('{1, 1, 0, 1, 3'd5, 0, 0, 1, 8'd0, 16'd0});
        tbl.push_back('{1, 1, 1, 1, 3'd5, 0, 0, 1, 8'd0, 16'd0});
        tbl.push_back('{1, 1, 1, 4, 3'd1, 1, 0, 0, 8'd0, 16'd1});
        tbl.push_back('{1, 1, 1, 8, 3'd2, 1, 1, 0, 8'd0, 16'd1});
        tbl.push_back('{1, 1, 1, 4, 3'd3, 1, 0, 0, 8'd0, 16'd1});
        tbl.push_back('{1, 1, 1, 3, 3'd4, 0, 0, 0, 8'd0, 16'd1});
        tbl.push_back('{1, 1, 1, 2, 3'd5, 0, 0, 1, 8'd0, 16'd1});
        tbl.push_back('{0, 1, 1, 1, 3'd0, 1, 1, 0, 8'd0, 16'd1});
        tbl.push_back('{0, 1, 1, 2, 3'd0, 1, 1, 0, 8'd0, 16'd1});
        for (int i = 0; i < tbl.size(); i++) begin
            enable_i = tbl[i].en;
            gt_pll_lock_i = tbl[i].pll;
            channel_up_i = tbl[i].cu;
            for (int k = 0; k < tbl[i].n; k++) begin
                tick();
                chk_all($sformatf("vec%0d.%0d", i, k), tbl[i].st, tbl[i].rpb,
                        tbl[i].pma, tbl[i].ok, tbl[i].st == 3'd6,
                        tbl[i].rc, tbl[i].dc);
            end
        end

        // Async reset in the middle of PMA
        enable_i = 1'b1;
        repeat (3) tick();
        chk("mid_pma_state", int'(state_o), S_PMA);
        #1 init_rst = 1'b1;
        #1 chk_all("async_rst", S_IDLE, 1, 1, 0, 0, 0, 0);
        do_reset();

        // Timeout / retry / fail / restart
        channel_up_i = 1'b0;
        wait_state(S_WAIT, 100, "to_wait1");
        count_in(S_WAIT, 100, n);
        chk("wait_len1", n, P_TO);
        chk_all("retry1", S_PBL, 1, 0, 0, 0, 1, 0);
        wait_state(S_WAIT, 100, "to_wait2");
        count_in(S_WAIT, 100, n);
        chk("wait_len2", n, P_TO);
        chk_all("fail", S_FAIL, 1, 1, 0, 1, 2, 0);
        repeat (10) tick();
        chk_all("fail_hold", S_FAIL, 1, 1, 0, 1, 2, 0);
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        chk_all("restart", S_PBL, 1, 0, 0, 0, 0, 0);

        // PLL lock stall in PB_HOLD
        gt_pll_lock_i = 1'b0;
        do_reset();
        wait_state(S_PBH, 50, "to_pbh");
        repeat (20) tick();
        chk("pll_stall", int'(state_o), S_PBH);
        gt_pll_lock_i = 1'b1;
        n = 0;
        while (state_o !== 3'(S_WAIT) && n < 20) begin
            tick();
            n++;
        end
        chk("pll_lat", n, 3);

        // channel_up glitch restarts stability count
        do_reset();
        wait_state(S_WAIT, 50, "to_wait_g");
        channel_up_i = 1'b1;
        repeat (2) tick();
        channel_up_i = 1'b0;
        repeat (6) tick();
        chk("glitch_no_up", int'(state_o), S_WAIT);
        channel_up_i = 1'b1;
        n = 0;
        while (state_o !== 3'(S_UP) && n < 20) begin
            tick();
            n++;
        end
        chk("up_lat", n, 5);

        // Random stimulus against the reference model
        restart_i = 1'b0;
        channel_up_i = 1'b0;
        gt_pll_lock_i = 1'b1;
        enable_i = 1'b1;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            enable_i = ($urandom_range(0, 199) != 0);
            restart_i = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) gt_pll_lock_i = ~gt_pll_lock_i;
            if ($urandom_range(0, 29) == 0) channel_up_i = ~channel_up_i;
            r_en = enable_i;
            r_rs = restart_i;
            r_cu = channel_up_i;
            r_pll = gt_pll_lock_i;
            tick();
            model_step(r_en, r_rs, r_cu, r_pll);
            chk_model($sformatf("rand%0d", c));
            if ($urandom_range(0, 799) == 0) begin
                init_rst = 1'b1;
                #1;
                model_reset();
                chk_model($sformatf("rand_rst%0d", c));
                #1 init_rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
